// File: rtl/mips_reg_writeback_if.sv
// mips_reg_writeback_if: ALU/load result, issue and register-file write bundle.
// MIPS_WB_FWD_EN adds the two forwarding lookup ports.
interface mips_reg_writeback_if;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        ld_valid, ld_ready, ld_signed, ld_err;
    logic [4:0]  ld_addr;
    logic [31:0] ld_word;
    logic [1:0]  ld_size, ld_off;
    logic        issue_valid, issue_ready;
    logic [4:0]  issue_addr;
    logic [31:0] busy;
    logic        RegWrite;
    logic [4:0]  WriteAddress;
    logic [31:0] DataIn;
`ifdef MIPS_WB_FWD_EN
    logic [4:0]  fwd_addr1, fwd_addr2;
    logic        fwd_hit1, fwd_hit2;
    logic [31:0] fwd_data1, fwd_data2;
`endif
    modport master (
        output alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_word, ld_size, ld_signed, ld_off,
               issue_valid, issue_addr,
`ifdef MIPS_WB_FWD_EN
        output fwd_addr1, fwd_addr2,
        input  fwd_hit1, fwd_hit2, fwd_data1, fwd_data2,
`endif
        input  alu_ready, ld_ready, ld_err, issue_ready, busy, RegWrite, WriteAddress, DataIn
    );
    modport slave (
        input  alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_word, ld_size, ld_signed, ld_off,
               issue_valid, issue_addr,
`ifdef MIPS_WB_FWD_EN
        input  fwd_addr1, fwd_addr2,
        output fwd_hit1, fwd_hit2, fwd_data1, fwd_data2,
`endif
        output alu_ready, ld_ready, ld_err, issue_ready, busy, RegWrite, WriteAddress, DataIn
    );
endinterface

// File: rtl/mips_reg_writeback.sv
// mips_reg_writeback: queued register-file write driver with load extraction and pending-write scoreboard.
// Optional queue bypass lookup enabled by MIPS_WB_FWD_EN.
module mips_reg_writeback #(
    parameter int DEPTH  = 4,
    parameter int PCNT_W = 2
) (
    input logic CLK,
    input logic reset,
    mips_reg_writeback_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LAST = (AW+1)'(DEPTH-1);
    localparam logic [AW:0] NEAR = (AW+1)'(DEPTH-2);
    logic [4:0]    q_addr [DEPTH];
    logic [31:0]   q_data [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr, alu_slot;
    logic [AW:0]   count;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   ld_ext, busy_v, sat;
    logic          ld_bad, ld_fire, alu_fire, ld_push, alu_push, pop;
    always_comb begin
        ld_byte = bus.ld_word[8*bus.ld_off +: 8];
        ld_half = bus.ld_off[1] ? bus.ld_word[31:16] : bus.ld_word[15:0];
        ld_ext  = bus.ld_size == 2'b00 ? {{24{bus.ld_signed & ld_byte[7]}}, ld_byte} :
                  bus.ld_size == 2'b01 ? {{16{bus.ld_signed & ld_half[15]}}, ld_half} : bus.ld_word;
        ld_bad  = (bus.ld_size == 2'b01 && bus.ld_off[0]) || (bus.ld_size == 2'b10 && bus.ld_off != 2'b00) ||
                  bus.ld_size == 2'b11;
    end
    // readiness looks only at the registered count; a same-cycle pop earns no credit
    assign bus.ld_ready  = count <= LAST;
    assign bus.alu_ready = count <= NEAR || (count == LAST && !bus.ld_valid);
    assign ld_fire  = bus.ld_valid && bus.ld_ready;
    assign alu_fire = bus.alu_valid && bus.alu_ready;
    assign ld_push  = ld_fire && !ld_bad && bus.ld_addr != 5'd0;
    assign alu_push = alu_fire && bus.alu_addr != 5'd0;
    assign alu_slot = wr_ptr + AW'(ld_push);
    assign pop = count != '0;
    assign bus.RegWrite     = pop;
    assign bus.WriteAddress = pop ? q_addr[rd_ptr] : 5'd0;
    assign bus.DataIn       = pop ? q_data[rd_ptr] : 32'd0;
    assign bus.issue_ready  = !sat[bus.issue_addr];
    assign bus.busy = busy_v;
    always_ff @(posedge CLK) begin
        if (ld_push) begin
            q_addr[wr_ptr] <= bus.ld_addr;
            q_data[wr_ptr] <= ld_ext;
        end
        if (alu_push) begin
            q_addr[alu_slot] <= bus.alu_addr;
            q_data[alu_slot] <= bus.alu_data;
        end
    end
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            bus.ld_err <= 1'b0;
        end else begin
            rd_ptr     <= rd_ptr + AW'(pop);
            wr_ptr     <= wr_ptr + AW'(ld_push) + AW'(alu_push);
            count      <= count + (AW+1)'(ld_push) + (AW+1)'(alu_push) - (AW+1)'(pop);
            bus.ld_err <= ld_fire && ld_bad;
        end
    end
    // register 0 never increments, so its counter stays at zero and busy[0] stays low
    for (genvar r = 0; r < 32; r++) begin : g_sb
        logic [PCNT_W-1:0] c;
        logic inc, dec;
        assign inc = bus.issue_valid && bus.issue_ready && bus.issue_addr == 5'(r) && r != 0;
        assign dec = pop && bus.WriteAddress == 5'(r) && c != '0;
        assign sat[r]    = c == '1;
        assign busy_v[r] = c != '0;
        always_ff @(posedge CLK or posedge reset) begin
            if (reset)
                c <= '0;
            else if (inc != dec)
                c <= inc ? c + 1'b1 : c - 1'b1;
        end
    end
`ifdef MIPS_WB_FWD_EN
    // walk oldest to youngest so the youngest match wins
    always_comb begin
        bus.fwd_hit1  = 1'b0;
        bus.fwd_hit2  = 1'b0;
        bus.fwd_data1 = 32'd0;
        bus.fwd_data2 = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((AW+1)'(i) < count && bus.fwd_addr1 != 5'd0 && q_addr[rd_ptr + AW'(i)] == bus.fwd_addr1) begin
                bus.fwd_hit1  = 1'b1;
                bus.fwd_data1 = q_data[rd_ptr + AW'(i)];
            end
            if ((AW+1)'(i) < count && bus.fwd_addr2 != 5'd0 && q_addr[rd_ptr + AW'(i)] == bus.fwd_addr2) begin
                bus.fwd_hit2  = 1'b1;
                bus.fwd_data2 = q_data[rd_ptr + AW'(i)];
            end
        end
    end
`endif
endmodule

// File: doc/mips_reg_writeback.md
Name: mips_reg_writeback

Overview:
- Write-side driver for the MIPS register file: collects results from the ALU and load paths, queues them, and issues at most one register write per cycle on the file's write port.
- Performs load byte/halfword extraction with sign/zero extension.
- Suppresses writes to $0.
- Keeps a per-register pending-write scoreboard that decode uses for hazard stalls.

Parameters:
- DEPTH, 4, write-queue entries (power of 2, min 2)
- PCNT_W, 2, width of the per-register pending counter (saturates at 2^PCNT_W-1)

Ports:
- CLK  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- alu_valid  in  1  ALU result offered
- alu_ready  out  1  ALU result accepted this cycle when alu_valid=1
- alu_addr  in  5  destination register
- alu_data  in  32  result
- ld_valid  in  1  load data offered
- ld_ready  out  1  load data accepted when ld_valid=1
- ld_addr  in  5  destination register
- ld_word  in  32  raw aligned memory word
- ld_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- ld_signed  in  1  1 = sign-extend, 0 = zero-extend
- ld_off  in  2  byte offset within word
- ld_err  out  1  one-cycle pulse: misaligned or reserved-size load dropped
- issue_valid  in  1  decode reserves a pending write
- issue_addr  in  5  register being reserved
- issue_ready  out  1  0 when counter of issue_addr is saturated
- busy  out  32  bit r = pending count of register r nonzero; bit 0 always 0
- RegWrite  out  1  register-file write enable
- WriteAddress  out  5  register-file write address
- DataIn  out  32  register-file write data

Behaviour:
- Reset (async): queue empty, all pending counters 0; RegWrite=0, WriteAddress=0, DataIn=0, ld_err=0, busy=0.
- Queue: FIFO of {addr, data}, count 0..DEPTH.
  - Head drives the write port: RegWrite = (count!=0); WriteAddress/DataIn = head fields when nonempty, else 0.
  - Head pops every cycle it is valid; the register file never stalls.
- Ready rules use registered count only, with no same-cycle pop credit:
  - ld_ready = (count <= DEPTH-1)
  - alu_ready = (count <= DEPTH-2) or (count == DEPTH-1 and !ld_valid)
- Both handshakes in one cycle: load entry enqueued ahead of ALU entry; up to 2 enqueues plus 1 pop per cycle.
- Latency: handshake at edge N → RegWrite high during cycle N+1 if queue was empty.
- addr==0 on either source: handshake completes, nothing enqueued, no error.
- Load extraction:
  - byte = ld_word[8*ld_off +: 8]
  - half = ld_word[16*ld_off[1] +: 16]
  - word = ld_word
  - Extend to 32 bits per ld_signed.
- Load errors: half with ld_off[0]=1, word with ld_off!=0, or ld_size=11.
  - Handshake completes; nothing enqueued.
  - ld_err=1 for the following cycle only.
- Scoreboard:
  - issue_valid && issue_ready && issue_addr!=0 increments cnt[issue_addr].
  - A pop with WriteAddress=r decrements cnt[r].
  - Same-cycle increment and decrement of the same r: net unchanged.
  - issue_ready = (cnt[issue_addr] != max).
  - Decrement at 0 is ignored (pop of an unreserved write).
  - busy is combinational from the counters.
- Reset mid-operation: queued writes are discarded, never written; the scoreboard clears.

Optional Feature:
- Macro: MIPS_WB_FWD_EN.
- With the macro defined:
  - Adds inputs fwd_addr1[4:0] and fwd_addr2[4:0].
  - Adds outputs fwd_hit1, fwd_data1[31:0], fwd_hit2, fwd_data2[31:0].
  - fwd_hitN=1 when a queue entry, including the head, matches fwd_addrN; fwd_addrN=0 never hits.
  - fwd_dataN = data of the youngest matching entry (combinational).
- Without the macro: these ports do not exist; no bypass logic.

Test Plan:
- Reset asserted mid-burst with 3 entries queued → RegWrite=0 immediately (async); no write to those addresses after release; busy=0.
- alu_valid, addr=5, data=0xDEADBEEF, queue empty → next cycle RegWrite=1, WriteAddress=5, DataIn=0xDEADBEEF; then RegWrite=0.
- ld_word=0x80FF7F01, byte: off=3 signed → 0xFFFFFF80; off=1 unsigned → 0x0000007F; half off=2 signed → 0xFFFF80FF; half off=1 → ld_err pulse, no write.
- Both sources valid every cycle, DEPTH=4 → ALU stalled whenever count≥3; write order ld,alu,ld,alu… preserved; no entry lost.
- issue addr=9 three times (cnt saturates at 3) → issue_ready=0 on the fourth try; after three pops to r9, busy[9]=0. issue and pop of r9 in the same cycle → busy[9] unchanged.
- alu_addr=0 with data 0x1234 → alu_ready=1, no RegWrite; issue_addr=0 → busy[0] stays 0.
